// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared widths and flush state for the disparity post-processing stages
package stereo_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pix_w(input int d);
    return cnt_w(d);
  endfunction

endpackage

// File: rtl/median9.sv
// rtl/median9.sv - combinational 19-comparator median-of-9 sorting network
module median9 #(
  parameter int W = 6
) (
  input  logic [9*W-1:0] win_i,
  output logic [W-1:0]   med_o
);

  // Compare-exchange pairs (lo, hi); after the last one slot 4 holds the 5th smallest.
  localparam logic [3:0] NET_LO [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
                                         4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
  localparam logic [3:0] NET_HI [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
                                         4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

  logic [W-1:0] v [9];
  logic [W-1:0] tmp;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      v[i] = win_i[i*W +: W];
    end
    tmp = '0;
    for (int k = 0; k < 19; k++) begin
      if (v[NET_LO[k]] > v[NET_HI[k]]) begin
        tmp          = v[NET_LO[k]];
        v[NET_LO[k]] = v[NET_HI[k]];
        v[NET_HI[k]] = tmp;
      end
    end
    med_o = v[4];
  end

endmodule

// File: rtl/disp_median3x3.sv
// rtl/disp_median3x3.sv - streaming 3x3 median filter for the disparity map
module disp_median3x3 import stereo_pkg::*; #(
  parameter  int D    = 64,
  parameter  int M    = 450,
  parameter  int L    = 375,
  localparam int DBIT = pix_w(D)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_dval,
  input  logic [DBIT-1:0] i_data,
  output logic            o_dval,
  output logic [DBIT-1:0] o_data,
  output logic            o_eof,
  output logic            o_busy,
  output logic            o_ovf
);

  localparam int CW = cnt_w(M);
  localparam int RW = cnt_w(L);
  localparam int FW = cnt_w(M + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(L - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(M);

  flush_state_e    state_q;
  logic            busy_q, ovf_q;
  logic [FW-1:0]   fcnt_q;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            accept, inject, adv, produce;
  logic [CW-1:0]   addr;
  logic [DBIT-1:0] px;

  assign accept  = i_dval && (state_q == RUN);
  assign inject  = (state_q == FLUSH);
  assign adv     = accept || inject;
  assign px      = accept ? i_data : '0;
  assign addr    = inject ? ((fcnt_q == FL_LAST) ? '0 : fcnt_q[CW-1:0]) : col_q;
  // Centre lags the input by M+1 pixels; flush pseudo-pixels always complete one.
  assign produce = inject || (row_q > RW'(1)) || ((row_q == RW'(1)) && (col_q != '0));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= RUN;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (i_dval && state_q == FLUSH) ovf_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (accept && row_q == ROW_LAST && col_q == COL_LAST) begin
            state_q <= FLUSH;
            busy_q  <= 1'b1;
            fcnt_q  <= '0;
          end
        end
        FLUSH: begin
          if (fcnt_q == FL_LAST) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers: lb1 holds row r-1, lb2 row r-2; read-before-write at addr.
  logic [DBIT-1:0] lb1_mem [M];
  logic [DBIT-1:0] lb2_mem [M];
  logic [DBIT-1:0] rd1_q, rd2_q;

  always_ff @(posedge i_clk) begin
    if (adv) begin
      rd1_q         <= lb1_mem[addr];
      rd2_q         <= lb2_mem[addr];
      lb1_mem[addr] <= px;
      lb2_mem[addr] <= lb1_mem[addr];
    end
  end

  logic            s1_v_q, s1_prod_q;
  logic [DBIT-1:0] s1_px_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_v_q    <= 1'b0;
      s1_prod_q <= 1'b0;
      s1_px_q   <= '0;
    end else begin
      s1_v_q    <= adv;
      s1_prod_q <= adv && produce;
      if (adv) s1_px_q <= px;
    end
  end

  // Window slot = row*3 + col, col 2 newest, slot 4 is the centre.
  logic [8:0][DBIT-1:0] win_q;
  logic                 s2_v_q, s2_border_q, s2_eof_q;
  logic [CW-1:0]        ocol_q;
  logic [RW-1:0]        orow_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      win_q       <= '0;
      s2_v_q      <= 1'b0;
      s2_border_q <= 1'b0;
      s2_eof_q    <= 1'b0;
      ocol_q      <= '0;
      orow_q      <= '0;
    end else begin
      s2_v_q <= s1_prod_q;
      if (s1_v_q) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= rd2_q;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= rd1_q;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= s1_px_q;
      end
      if (s1_prod_q) begin
        s2_border_q <= (orow_q == '0) || (orow_q == ROW_LAST) || (ocol_q == '0) || (ocol_q == COL_LAST);
        s2_eof_q    <= (orow_q == ROW_LAST) && (ocol_q == COL_LAST);
        if (ocol_q == COL_LAST) begin
          ocol_q <= '0;
          orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end
    end
  end

  logic [DBIT-1:0] med;

  median9 #(.W(DBIT)) u_median9 (
    .win_i (win_q),
    .med_o (med)
  );

  logic            dval_q, eof_q;
  logic [DBIT-1:0] data_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dval_q <= 1'b0;
      eof_q  <= 1'b0;
      data_q <= '0;
    end else begin
      dval_q <= s2_v_q;
      eof_q  <= s2_v_q && s2_eof_q;
      if (s2_v_q) data_q <= s2_border_q ? win_q[4] : med;
    end
  end

  assign o_dval = dval_q;
  assign o_data = data_q;
  assign o_eof  = eof_q;
  assign o_busy = busy_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_disp_median3x3.sv
// tb/tb_disp_median3x3.sv - randomized self-checking bench for disp_median3x3
module tb_disp_median3x3;

  localparam int D  = 64;
  localparam int M  = 8;
  localparam int L  = 6;
  localparam int DB = 6;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_dval = 1'b0;
  logic [DB-1:0] i_data = '0;
  logic          o_dval;
  logic [DB-1:0] o_data;
  logic          o_eof;
  logic          o_busy;
  logic          o_ovf;

  int n_vec = 0;
  int n_err = 0;
  int busy_cyc = 0;
  int img [L][M];
  int exp_d [$];
  int exp_e [$];
  int got_d [$];
  int got_e [$];

  always #5 i_clk = ~i_clk;

  disp_median3x3 #(.D(D), .M(M), .L(L)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_dval (i_dval),
    .i_data (i_data),
    .o_dval (o_dval),
    .o_data (o_data),
    .o_eof  (o_eof),
    .o_busy (o_busy),
    .o_ovf  (o_ovf)
  );

  always @(negedge i_clk) begin
    if (o_dval) begin
      got_d.push_back(int'(o_data));
      got_e.push_back(int'(o_eof));
    end
    if (o_busy) busy_cyc++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: border centres pass through, interior takes the 5th smallest of 9.
  function automatic void model_frame();
    for (int r = 0; r < L; r++) begin
      for (int c = 0; c < M; c++) begin
        int q [$];
        int e;
        if (r == 0 || r == L-1 || c == 0 || c == M-1) begin
          e = img[r][c];
        end else begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              q.push_back(img[r+dr][c+dc]);
          q.sort();
          e = q[4];
        end
        exp_d.push_back(e);
        exp_e.push_back((r == L-1 && c == M-1) ? 1 : 0);
      end
    end
  endfunction

  task automatic fill_const(input int v);
    for (int r = 0; r < L; r++)
      for (int c = 0; c < M; c++)
        img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < L; r++)
      for (int c = 0; c < M; c++)
        img[r][c] = ($urandom_range(3) == 0) ? int'($urandom_range(63)) : int'($urandom_range(20, 12));
  endtask

  // Called at a negedge; returns at the first negedge with o_busy low after the flush.
  task automatic run_frame(input int gap_pct, input bit drain, input bit poke);
    int t;
    model_frame();
    t = 0;
    while (o_busy && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    for (int r = 0; r < L; r++) begin
      for (int c = 0; c < M; c++) begin
        while ($urandom_range(99) < gap_pct) begin
          i_dval = 1'b0;
          @(negedge i_clk);
        end
        i_dval = 1'b1;
        i_data = DB'(img[r][c]);
        @(negedge i_clk);
      end
    end
    i_dval = 1'b0;
    chk("busy_rise", int'(o_busy), 1);
    t = 0;
    while (o_busy && t < 100) begin
      i_dval = poke && (t == 3);
      i_data = 6'd63;
      @(negedge i_clk);
      t++;
    end
    i_dval = 1'b0;
    chk("busy_fall_in_time", (t < 100) ? 1 : 0, 1);
    if (drain) repeat (4) @(negedge i_clk);
  endtask

  task automatic check_out(input string tag);
    int n;
    chk({tag, "_count"}, got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, got_d[i], exp_d[i]);
      chk({tag, "_eof"}, got_e[i], exp_e[i]);
    end
    got_d.delete();
    got_e.delete();
    exp_d.delete();
    exp_e.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_dval", int'(o_dval), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_eof", int'(o_eof), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ovf", int'(o_ovf), 0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // Constant frame followed back-to-back by an interior impulse frame.
    fill_const(5);
    busy_cyc = 0;
    run_frame(0, 1'b0, 1'b0);
    chk("busy_cycles", busy_cyc, M + 1);
    fill_const(10);
    img[2][3] = 63;
    run_frame(0, 1'b1, 1'b0);
    check_out("const_impulse");

    fill_const(10);
    img[0][4] = 63;
    run_frame(0, 1'b1, 1'b0);
    check_out("border");
    chk("ovf_idle", int'(o_ovf), 0);

    for (int r = 0; r < L; r++)
      for (int c = 0; c < M; c++)
        img[r][c] = (r + c) % 64;
    run_frame(30, 1'b1, 1'b0);
    check_out("ramp_gaps");

    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run_frame(30, 1'b1, 1'b0);
      check_out("rand_gaps");
    end

    fill_rand();
    run_frame(10, 1'b1, 1'b1);
    chk("ovf_set", int'(o_ovf), 1);
    fill_rand();
    run_frame(0, 1'b1, 1'b0);
    chk("ovf_sticky", int'(o_ovf), 1);
    check_out("ovf");

    // Reset in the middle of row 3.
    for (int p = 0; p < 3*M + 3; p++) begin
      i_dval = 1'b1;
      i_data = DB'($urandom_range(63));
      @(negedge i_clk);
    end
    chk("pre_rst_dval", int'(o_dval), 1);
    i_rstn = 1'b0;
    i_dval = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_dval", int'(o_dval), 0);
    chk("mid_rst_ovf", int'(o_ovf), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    got_d.delete();
    got_e.delete();
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    fill_rand();
    run_frame(20, 1'b1, 1'b0);
    check_out("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disp_median3x3.md
# disp_median3x3

Streaming 3x3 median filter for the disparity map produced by `stereo_match`. It sits directly downstream of the matcher and consumes its `o_dval` / `o_data` raster stream. It removes isolated outliers and LRCC-invalidated speckles before the map leaves the core. Two line buffers and a 3x3 window feed a registered median-of-9 network. A small FSM flushes the final row plus one pixel at end of frame.

## Interface
- D, 64, disparity range; DBIT = $clog2(D) is the pixel width.
- M, 450, disparity-map width in pixels.
- L, 375, disparity-map height in rows.
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_dval  in  1  input pixel valid.
- i_data  in  DBIT  input disparity, raster order.
- o_dval  out  1  output pixel valid.
- o_data  out  DBIT  filtered disparity.
- o_eof  out  1  pulses high together with o_dval on the last output pixel of a frame.
- o_busy  out  1  high while the block flushes; upstream must hold i_dval low.
- o_ovf  out  1  sticky error: i_dval was asserted while o_busy was high.

## Operation
- Input counters col_in (0..M-1) and row_in (0..L-1) advance on each accepted pixel and wrap at M and L.
- Pixel stores:
  - Two line buffers of M x DBIT (row r-1 and row r-2), written at col_in.
  - A 3x3 window shift register shifts by one column per accepted pixel.
- Window centre is the pixel at (row_in-1, col_in-1).
- The first M+1 accepted pixels of a frame produce no output. Every later accepted pixel produces exactly one output.
- Border pixels pass through unchanged: the centre value is output as is. A border pixel is any centre with row 0, row L-1, col 0 or col M-1.
- Interior pixels output the median of the 9 window values. The median uses unsigned compare, so the result equals the 5th smallest value.
- FSM states:
  - RUN: entered from reset.
  - RUN -> FLUSH: on acceptance of pixel (L-1, M-1).
  - FLUSH: o_busy=1. Injects one zero pseudo-pixel per cycle for M+1 cycles. These only ever reach border centres, so they never influence a median.
  - FLUSH -> RUN: after the last pseudo-pixel. Counters are already zero for the next frame.
- Output count is exactly M*L per frame. o_eof accompanies output (L-1, M-1).
- i_dval during FLUSH: the sample is dropped, o_ovf is set, and the flush continues unaltered.
- i_dval low in RUN stalls the whole pipeline front. The output stage still drains in-flight results.

## Timing
- Reset values: o_dval=0, o_data=0, o_eof=0, o_busy=0, o_ovf=0. Counters, window and FSM are cleared (RUN).
- Line buffer contents are not reset, because stale data only reaches border centres.
- Latency: an input sampled at edge k produces its output, when one is produced, with o_dval high in the cycle after edge k+2. The stages are window register, then median register.
- Pseudo-pixels follow the same 2-edge latency.
- o_busy rises the cycle after the edge accepting (L-1, M-1). It falls the cycle after the edge consuming the last pseudo-pixel.
- Back-to-back frames: the first pixel of the next frame may be presented in the cycle o_busy is low again.
- Reset mid-frame or mid-flush:
  - All counters and the FSM return to RUN/0 immediately.
  - In-flight outputs are discarded.
  - o_ovf is cleared.

## Structure
- Shared package `stereo_pkg`:
  - DBIT/width helper functions (clog2-based counter widths for M and L).
  - The FSM state enum {RUN, FLUSH}, shared with later post-processing stages.
- Sub-module `median9`: a combinational 19-comparator sorting network with 9 DBIT inputs and the median as output. It is instantiated once and followed by the output register in the parent.
- Line buffers are inferred single-port RAMs (read-before-write at col_in).

## Test plan
- M=8, L=6, constant frame of value 5 -> 48 outputs, all 5. o_eof is high only on the 48th. o_busy is high for 9 cycles.
- Single interior impulse 63 at (2,3) on a field of 10 -> output (2,3)=10, all others 10.
- Impulse 63 at border (0,4) -> output (0,4)=63, because border pixels pass through.
- Ramp where pixel = (row+col) mod 64 with random 30% i_dval gaps -> output matches a software median/passthrough model bit-exact, in order, with the same count.
- i_dval pulsed during FLUSH -> o_ovf goes to 1 and stays there. The frame still yields 48 outputs, and the extra sample is absent.
- Reset asserted mid-row 3 -> o_dval goes to 0 next cycle. A fresh frame afterwards produces the correct 48 outputs.
